// File: rtl/vote_pkg.sv
// Shared types and defaults for the three-requester vote round controller.
package vote_pkg;

  localparam int unsigned NUM_VOTERS  = 3;
  localparam int unsigned DEF_TIMEOUT = 16;
  localparam int unsigned DEF_CNT_W   = 8;
  localparam int unsigned TIMER_W     = 8;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    EVAL,
    HOLD
  } state_e;

endpackage

// File: rtl/my_module.sv
// Decision datapath: majority of the three input votes, purely combinational.
module my_module (
  input  logic i0,
  input  logic i1,
  input  logic i2,
  output logic b
);

  assign b = (i0 & i1) | (i0 & i2) | (i1 & i2);

endmodule

// File: rtl/vote_round_controller.sv
// Collects one vote per requester, evaluates my_module once, and holds the
// decision until downstream accepts it. A watchdog closes silent rounds.
module vote_round_controller
  import vote_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEF_TIMEOUT,
  parameter int unsigned CNT_W   = DEF_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [NUM_VOTERS-1:0] vote_valid,
  input  logic [NUM_VOTERS-1:0] vote_value,
  output logic [NUM_VOTERS-1:0] vote_ack,
  output logic                  busy,
  output logic                  dec_valid,
  input  logic                  dec_ready,
  output logic                  dec_value,
  output logic                  dec_timeout,
  output logic [CNT_W-1:0]      dec_count
);

  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

  state_e                  state_q, state_d;
  logic [NUM_VOTERS-1:0]   votes_q, votes_d;
  logic [NUM_VOTERS-1:0]   got_q, got_d;
  logic [TIMER_W-1:0]      timer_q, timer_d;
  logic                    dec_valid_q, dec_valid_d;
  logic                    dec_value_q, dec_value_d;
  logic                    dec_timeout_q, dec_timeout_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [NUM_VOTERS-1:0]   ack;
  logic                    eval_b;

  my_module u_decide (
    .i0 (votes_q[0]),
    .i1 (votes_q[1]),
    .i2 (votes_q[2]),
    .b  (eval_b)
  );

  always_comb begin
    state_d       = state_q;
    votes_d       = votes_q;
    got_d         = got_q;
    timer_d       = timer_q;
    dec_valid_d   = dec_valid_q;
    dec_value_d   = dec_value_q;
    dec_timeout_d = dec_timeout_q;
    cnt_d         = cnt_q;
    ack           = '0;

    unique case (state_q)
      IDLE: begin
        votes_d       = '0;
        got_d         = '0;
        timer_d       = '0;
        dec_timeout_d = 1'b0;
        if (start) begin
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        ack     = vote_valid & ~got_q;
        votes_d = (votes_q & ~ack) | (vote_value & ack);
        got_d   = got_q | ack;
        timer_d = timer_q + TIMER_W'(1);
        // A completing vote wins over the watchdog in the expiry cycle.
        if (got_d == '1) begin
          state_d = EVAL;
        end else if (timer_q == TIMER_LAST) begin
          state_d       = EVAL;
          dec_timeout_d = 1'b1;
        end
      end
      EVAL: begin
        dec_value_d = eval_b;
        dec_valid_d = 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        if (dec_valid_q && dec_ready) begin
          dec_valid_d = 1'b0;
          cnt_d       = cnt_q + CNT_W'(1);
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      votes_q       <= '0;
      got_q         <= '0;
      timer_q       <= '0;
      dec_valid_q   <= 1'b0;
      dec_value_q   <= 1'b0;
      dec_timeout_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      votes_q       <= votes_d;
      got_q         <= got_d;
      timer_q       <= timer_d;
      dec_valid_q   <= dec_valid_d;
      dec_value_q   <= dec_value_d;
      dec_timeout_q <= dec_timeout_d;
      cnt_q         <= cnt_d;
    end
  end

  assign vote_ack    = ack;
  assign busy        = (state_q != IDLE);
  assign dec_valid   = dec_valid_q;
  assign dec_value   = dec_value_q;
  assign dec_timeout = dec_timeout_q;
  assign dec_count   = cnt_q;

endmodule

// File: tb/tb_vote_round_controller.sv
// Directed bench for vote_round_controller with a round-level reference model.
module tb_vote_round_controller;

  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned CNT_W   = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [2:0]       vote_valid;
  logic [2:0]       vote_value;
  logic [2:0]       vote_ack;
  logic             busy;
  logic             dec_valid;
  logic             dec_ready;
  logic             dec_value;
  logic             dec_timeout;
  logic [CNT_W-1:0] dec_count;

  int n_cmp = 0;
  int n_bad = 0;

  vote_round_controller #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .vote_valid  (vote_valid),
    .vote_value  (vote_value),
    .vote_ack    (vote_ack),
    .busy        (busy),
    .dec_valid   (dec_valid),
    .dec_ready   (dec_ready),
    .dec_value   (dec_value),
    .dec_timeout (dec_timeout),
    .dec_count   (dec_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic majority(input logic [2:0] v);
    return $countones(v) >= 2;
  endfunction

  // Reference model: 0 idle, 1 collecting, 2 deciding, 3 offering.
  int               m_mode;
  int               m_cycles;
  logic [2:0]       m_got, m_vote, m_acc;
  logic             m_valid, m_value, m_to;
  logic [CNT_W-1:0] m_count;

  assign m_acc = (m_mode == 1) ? (vote_valid & ~m_got) : 3'b000;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode <= 0; m_cycles <= 0; m_got <= '0; m_vote <= '0;
      m_valid <= 1'b0; m_value <= 1'b0; m_to <= 1'b0; m_count <= '0;
    end else begin
      case (m_mode)
        0: begin
          m_got <= '0; m_vote <= '0; m_cycles <= 0; m_to <= 1'b0;
          if (start) m_mode <= 1;
        end
        1: begin
          m_vote   <= (m_vote & ~m_acc) | (vote_value & m_acc);
          m_got    <= m_got | m_acc;
          m_cycles <= m_cycles + 1;
          if ((m_got | m_acc) == 3'b111) m_mode <= 2;
          else if (m_cycles + 1 == int'(TIMEOUT)) begin
            m_mode <= 2;
            m_to   <= 1'b1;
          end
        end
        2: begin
          m_value <= majority(m_vote);
          m_valid <= 1'b1;
          m_mode  <= 3;
        end
        default: begin
          if (dec_ready) begin
            m_valid <= 1'b0;
            m_count <= m_count + CNT_W'(1);
            m_mode  <= 0;
          end
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("ack", 32'(vote_ack), 32'(m_acc));
      chk("busy", 32'(busy), 32'(m_mode != 0));
      chk("dec_valid", 32'(dec_valid), 32'(m_valid));
      chk("dec_value", 32'(dec_value), 32'(m_value));
      chk("dec_timeout", 32'(dec_timeout), 32'(m_to));
      chk("dec_count", 32'(dec_count), 32'(m_count));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_valid(input string nm);
    int n = 0;
    while (dec_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk(nm, 32'(dec_valid), 32'd1);
  endtask

  task automatic handshake();
    dec_ready = 1'b1;
    tick();
    dec_ready = 1'b0;
  endtask

  task automatic quick_round(input logic [2:0] val);
    do_start();
    vote_valid = 3'b111;
    vote_value = val;
    tick();
    vote_valid = '0;
    wait_valid("quick_wait");
    handshake();
  endtask

  task automatic staggered(input logic k1_val, input logic exp_val);
    do_start();
    for (int c = 1; c <= 7; c++) begin
      vote_valid = '0;
      vote_value = '0;
      case (c)
        2: begin vote_valid = 3'b001; vote_value = 3'b001; end
        4: begin vote_valid = 3'b001; vote_value = 3'b000; end
        5: begin vote_valid = 3'b100; vote_value = 3'b100; end
        7: begin vote_valid = 3'b010; vote_value = {1'b0, k1_val, 1'b0}; end
        default: ;
      endcase
      #1;
      if (c == 2) chk("stag_ack2", 32'(vote_ack), 32'(3'b001));
      if (c == 4) chk("stag_repeat_noack", 32'(vote_ack), 32'(3'b000));
      if (c == 6) chk("stag_busy", 32'(busy), 32'd1);
      tick();
    end
    vote_valid = '0;
    wait_valid("stag_wait");
    chk("stag_value", 32'(dec_value), 32'(exp_val));
    chk("stag_timeout", 32'(dec_timeout), 32'd0);
    handshake();
  endtask

  initial begin
    logic       hv, hval, hto;
    logic [7:0] maj_tab;
    rst_n = 1'b0; start = 1'b0; vote_valid = '0; vote_value = '0; dec_ready = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(dec_valid), 32'd0);
    chk("rst_count", 32'(dec_count), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // All three votes in the first COLLECT cycle.
    do_start();
    vote_valid = 3'b111;
    vote_value = 3'b101;
    #1;
    chk("t1_ack", 32'(vote_ack), 32'(3'b111));
    tick();
    vote_valid = '0;
    chk("t1_not_yet", 32'(dec_valid), 32'd0);
    tick();
    chk("t1_valid", 32'(dec_valid), 32'd1);
    chk("t1_value", 32'(dec_value), 32'd1);
    chk("t1_timeout", 32'(dec_timeout), 32'd0);
    handshake();
    chk("t1_count", 32'(dec_count), 32'd1);
    chk("t1_idle", 32'(busy), 32'd0);

    staggered(1'b1, 1'b1);
    staggered(1'b0, 1'b1);

    // Watchdog: only requester 1 votes.
    do_start();
    vote_valid = 3'b010; vote_value = 3'b010;
    tick();
    vote_valid = '0; vote_value = '0;
    for (int c = 2; c <= 16; c++) tick();
    chk("to_not_early", 32'(dec_valid), 32'd0);
    tick();
    chk("to_valid", 32'(dec_valid), 32'd1);
    chk("to_flag", 32'(dec_timeout), 32'd1);
    chk("to_value", 32'(dec_value), 32'd0);
    handshake();

    // Last vote lands in the expiry cycle.
    do_start();
    vote_valid = 3'b011; vote_value = 3'b001;
    tick();
    vote_valid = '0; vote_value = '0;
    for (int c = 2; c <= 15; c++) tick();
    vote_valid = 3'b100; vote_value = 3'b100;
    #1;
    chk("exp_ack", 32'(vote_ack), 32'(3'b100));
    tick();
    vote_valid = '0; vote_value = '0;
    tick();
    chk("exp_valid", 32'(dec_valid), 32'd1);
    chk("exp_timeout", 32'(dec_timeout), 32'd0);
    chk("exp_value", 32'(dec_value), 32'd1);
    handshake();

    // Backpressure with start pulses and vote traffic.
    do_start();
    vote_valid = 3'b011; vote_value = 3'b011;
    tick();
    vote_valid = '0;
    for (int c = 0; c < 15; c++) tick();
    wait_valid("bp_wait");
    hv = dec_valid; hval = dec_value; hto = dec_timeout;
    for (int i = 0; i < 10; i++) begin
      start = i[0];
      vote_valid = 3'(i);
      vote_value = 3'(~i);
      #1;
      chk("bp_noack", 32'(vote_ack), 32'd0);
      tick();
      chk("bp_valid", 32'(dec_valid), 32'(hv));
      chk("bp_value", 32'(dec_value), 32'(hval));
      chk("bp_timeout", 32'(dec_timeout), 32'(hto));
    end
    start = 1'b1; vote_valid = '0;
    handshake();
    start = 1'b0;
    chk("bp_start_ignored", 32'(busy), 32'd0);
    tick();
    chk("bp_still_idle", 32'(busy), 32'd0);

    // Every vote pattern.
    maj_tab = 8'b1110_1000;
    for (int p = 0; p < 8; p++) begin
      do_start();
      vote_valid = 3'b111; vote_value = 3'(p);
      tick();
      vote_valid = '0;
      wait_valid("sweep_wait");
      chk("sweep_value", 32'(dec_value), 32'(maj_tab[p]));
      handshake();
    end

    // Reset mid-COLLECT after a round left dec_value and dec_count nonzero.
    do_start();
    vote_valid = 3'b001; vote_value = 3'b001;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_ack", 32'(vote_ack), 32'd0);
    chk("arst_valid", 32'(dec_valid), 32'd0);
    chk("arst_value", 32'(dec_value), 32'd0);
    chk("arst_timeout", 32'(dec_timeout), 32'd0);
    chk("arst_count", 32'(dec_count), 32'd0);
    vote_valid = '0; vote_value = '0;
    tick();
    rst_n = 1'b1;
    tick();

    // Counter wrap.
    for (int r = 0; r < 255; r++) quick_round(3'(r));
    chk("wrap_top", 32'(dec_count), 32'd255);
    quick_round(3'b110);
    chk("wrap_zero", 32'(dec_count), 32'd0);

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
